// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data accesses win; fetch responses killed by a taken branch are dropped.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_valid_o,
    output logic            if_stall_o,
    input  logic            if_flush_i,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [DW/8-1:0] dm_be_i,
    input  logic [AW-1:0]   dm_addr_i,
    input  logic [DW-1:0]   dm_wdata_i,
    output logic [DW-1:0]   dm_rdata_o,
    output logic            dm_valid_o,
    output logic            dm_stall_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            discard_q, discard_d;
    logic            we_q, we_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rsp;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            discard_q <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (dm_req_i) begin
                    owner_d = OWN_DM;
                    we_d    = dm_we_i;
                    be_d    = dm_be_i;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                    state_d = REQ;
                end else if (if_req_i && !if_flush_i) begin
                    // a flushed pc is stale, so wait for the redirected one
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    be_d    = '1;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (if_flush_i && owner_q == OWN_IF) discard_d = 1'b1;
                if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (if_flush_i && owner_q == OWN_IF) discard_d = 1'b1;
                if (mem_rvalid_i) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp = (state_q == WAIT) && mem_rvalid_i;

    assign if_valid_o = rsp && owner_q == OWN_IF && !discard_q && !if_flush_i;
    assign dm_valid_o = rsp && owner_q == OWN_DM;
    assign if_rdata_o = mem_rdata_i;
    assign dm_rdata_o = mem_rdata_i;
    assign if_stall_o = if_req_i && !if_valid_o;
    assign dm_stall_o = dm_req_i && !dm_valid_o;

    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter.
// Inputs change 1 time unit after posedge; outputs checked 1 unit later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_req_i, if_flush_i;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        if_valid_o, if_stall_o;
    logic        dm_req_i, dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        dm_valid_o, dm_stall_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
        .if_stall_o(if_stall_o), .if_flush_i(if_flush_i),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
        .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        if_req_i = 0; if_flush_i = 0; if_addr_i = 0;
        dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (2) tick();
        if_req_i = 1; mem_rvalid_i = 1;
        settle();
        chk("rst mem_req", mem_req_o, 0);
        chk("rst mem_we", mem_we_o, 0);
        chk("rst mem_be", mem_be_o, 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst mem_wdata", mem_wdata_o, 0);
        chk("rst if_valid", if_valid_o, 0);
        chk("rst dm_valid", dm_valid_o, 0);
        chk("rst if_stall", if_stall_o, 1);
        if_req_i = 0; mem_rvalid_i = 0;
        #2 rst_ni = 1'b1;

        // single fetch
        tick(); if_req_i = 1; if_addr_i = 32'h10; settle();
        chk("f1 N req", mem_req_o, 0);
        chk("f1 N stall", if_stall_o, 1);
        tick(); mem_gnt_i = 1; settle();
        chk("f1 N+1 req", mem_req_o, 1);
        chk("f1 N+1 addr", mem_addr_o, 32'h10);
        chk("f1 N+1 be", mem_be_o, 4'hf);
        chk("f1 N+1 we", mem_we_o, 0);
        chk("f1 N+1 stall", if_stall_o, 1);
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13; settle();
        chk("f1 N+2 valid", if_valid_o, 1);
        chk("f1 N+2 rdata", if_rdata_o, 32'h13);
        chk("f1 N+2 stall", if_stall_o, 0);
        chk("f1 N+2 req", mem_req_o, 0);
        tick(); if_req_i = 0; mem_rvalid_i = 0; settle();
        chk("f1 N+3 valid", if_valid_o, 0);

        // simultaneous IF and DM, DM wins
        tick(); if_req_i = 1; if_addr_i = 32'h14;
        dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hf; dm_addr_i = 32'h100; settle();
        chk("pr N istall", if_stall_o, 1);
        chk("pr N dstall", dm_stall_o, 1);
        tick(); mem_gnt_i = 1; settle();
        chk("pr N+1 req", mem_req_o, 1);
        chk("pr N+1 addr", mem_addr_o, 32'h100);
        chk("pr N+1 istall", if_stall_o, 1);
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA5555; settle();
        chk("pr N+2 dvalid", dm_valid_o, 1);
        chk("pr N+2 drdata", dm_rdata_o, 32'hAAAA5555);
        chk("pr N+2 ivalid", if_valid_o, 0);
        chk("pr N+2 istall", if_stall_o, 1);
        tick(); dm_req_i = 0; mem_rvalid_i = 0; settle();
        chk("pr N+3 req", mem_req_o, 0);
        chk("pr N+3 istall", if_stall_o, 1);
        tick(); mem_gnt_i = 1; settle();
        chk("pr N+4 req", mem_req_o, 1);
        chk("pr N+4 addr", mem_addr_o, 32'h14);
        chk("pr N+4 istall", if_stall_o, 1);
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00A00093; settle();
        chk("pr N+5 ivalid", if_valid_o, 1);
        chk("pr N+5 rdata", if_rdata_o, 32'h00A00093);
        chk("pr N+5 istall", if_stall_o, 0);
        tick(); if_req_i = 0; mem_rvalid_i = 0; settle();

        // store with gnt delayed 3 cycles
        tick(); dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011;
        dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF; settle();
        for (int i = 0; i < 4; i++) begin
            tick();
            dm_we_i = 0; dm_be_i = 4'hf; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
            mem_gnt_i = (i == 3);
            settle();
            chk("st req", mem_req_o, 1);
            chk("st we", mem_we_o, 1);
            chk("st be", mem_be_o, 4'b0011);
            chk("st addr", mem_addr_o, 32'h200);
            chk("st wdata", mem_wdata_o, 32'hDEADBEEF);
            chk("st dvalid", dm_valid_o, 0);
        end
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; settle();
        chk("st ack req", mem_req_o, 0);
        chk("st ack dvalid", dm_valid_o, 1);
        chk("st ack dstall", dm_stall_o, 0);
        tick(); dm_req_i = 0; mem_rvalid_i = 0; settle();
        chk("st done dvalid", dm_valid_o, 0);

        // flush while fetch in WAIT
        tick(); if_req_i = 1; if_addr_i = 32'h20; settle();
        tick(); mem_gnt_i = 1; settle();
        tick(); mem_gnt_i = 0; if_flush_i = 1; if_addr_i = 32'h40; settle();
        chk("fl wait ivalid", if_valid_o, 0);
        tick(); if_flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD; settle();
        chk("fl drop ivalid", if_valid_o, 0);
        chk("fl drop istall", if_stall_o, 1);
        tick(); mem_rvalid_i = 0; settle();
        chk("fl idle req", mem_req_o, 0);
        tick(); mem_gnt_i = 1; settle();
        chk("fl new req", mem_req_o, 1);
        chk("fl new addr", mem_addr_o, 32'h40);
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55; settle();
        chk("fl new ivalid", if_valid_o, 1);
        chk("fl new rdata", if_rdata_o, 32'h55);
        tick(); if_req_i = 0; mem_rvalid_i = 0; settle();

        // flush coincident with rvalid
        tick(); if_req_i = 1; if_addr_i = 32'h80; settle();
        tick(); mem_gnt_i = 1; settle();
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; if_flush_i = 1; settle();
        chk("fc ivalid", if_valid_o, 0);
        tick(); if_req_i = 0; if_flush_i = 0; mem_rvalid_i = 0; settle();
        chk("fc idle req", mem_req_o, 0);

        // flush during DM transaction
        tick(); dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hf; dm_addr_i = 32'h300; settle();
        tick(); mem_gnt_i = 1; if_flush_i = 1; settle();
        chk("dfl req", mem_req_o, 1);
        chk("dfl addr", mem_addr_o, 32'h300);
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77; settle();
        chk("dfl dvalid", dm_valid_o, 1);
        chk("dfl drdata", dm_rdata_o, 32'h77);
        tick(); dm_req_i = 0; if_flush_i = 0; mem_rvalid_i = 0; settle();

        // reset during WAIT
        tick(); if_req_i = 1; if_addr_i = 32'h90; settle();
        tick(); mem_gnt_i = 1; settle();
        tick(); mem_gnt_i = 0; settle();
        rst_ni = 1'b0; mem_rvalid_i = 1; settle();
        chk("rw ivalid", if_valid_o, 0);
        chk("rw req", mem_req_o, 0);
        chk("rw addr", mem_addr_o, 0);
        chk("rw be", mem_be_o, 0);
        tick(); mem_rvalid_i = 0; if_addr_i = 32'hA0; settle();
        rst_ni = 1'b1;
        tick(); mem_gnt_i = 1; settle();
        chk("rw2 req", mem_req_o, 1);
        chk("rw2 addr", mem_addr_o, 32'hA0);
        tick(); mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99; settle();
        chk("rw2 ivalid", if_valid_o, 1);
        chk("rw2 rdata", if_rdata_o, 32'h99);
        tick(); if_req_i = 0; mem_rvalid_i = 0; settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
